// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : decode_issue_ctrl
//  Purpose  : Buffers fetched instruction/PC pairs in a small FIFO and issues
//             them to decode one at a time as a pulse/gap handshake, gated by
//             ROB availability. A flush discards all queued and in-flight work.
//  Revision : 1.0  initial release
// ============================================================================
module decode_issue_ctrl #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             fetch_valid,
   input  logic [31:0]      fetch_instr,
   input  logic [31:0]      fetch_pc,
   output logic             fetch_ready,
   input  logic             rob_available,
   input  logic             flush,
   output logic             decode_pulse,
   output logic [31:0]      decode_instr,
   output logic [31:0]      decode_pc,
   output logic [PTR_W:0]   queue_count,
   output logic [31:0]      issued_total
);

   // Issue sequencer states: a pulse is always followed by a guaranteed low cycle
   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_pulse = 2'd1;
   localparam logic [1:0] c_gap   = 2'd2;

   localparam logic [PTR_W:0] c_full = (PTR_W+1)'(DEPTH);

   logic [31:0]      r_mem_instr [DEPTH];
   logic [31:0]      r_mem_pc    [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic [1:0]       r_state;
   logic             r_pulse;
   logic [31:0]      r_instr;
   logic [31:0]      r_pc;
   logic [31:0]      r_issued;

   logic             w_push;
   logic             w_pop;
   logic             w_issue;

   // Readiness looks only at the registered count, so a same-cycle pop never
   // opens a slot for a push into a full queue.
   assign fetch_ready = (r_count != c_full);
   assign w_push      = fetch_valid && fetch_ready && !flush;
   // The head is retired when the pulse ends, regardless of rob_available;
   // rejection downstream is the ROB's concern, never a re-issue.
   assign w_pop       = (r_state == c_pulse) && !flush;
   assign w_issue     = (r_state == c_idle) && (r_count != '0) && rob_available && !flush;

   // FIFO storage: written on accepted pushes, contents survive reset
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem_instr[r_wr_ptr] <= fetch_instr;
         r_mem_pc[r_wr_ptr]    <= fetch_pc;
      end
   end

   // Queue pointers and occupancy; flush empties the queue and drops any push
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
      end
   end

   // Issue sequencer: load head and raise pulse, retire head, then a low gap
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= c_idle;
         r_pulse  <= 1'b0;
         r_instr  <= '0;
         r_pc     <= '0;
         r_issued <= '0;
      end else if (flush) begin
         // Decode payload is deliberately left as-is on flush
         r_state <= c_idle;
         r_pulse <= 1'b0;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_issue) begin
                  r_state <= c_pulse;
                  r_pulse <= 1'b1;
                  r_instr <= r_mem_instr[r_rd_ptr];
                  r_pc    <= r_mem_pc[r_rd_ptr];
               end
            end
            c_pulse: begin
               r_state  <= c_gap;
               r_pulse  <= 1'b0;
               r_issued <= r_issued + 32'd1;
            end
            c_gap: begin
               r_state <= c_idle;
            end
            default: begin
               r_state <= c_idle;
               r_pulse <= 1'b0;
            end
         endcase
      end
   end

   assign decode_pulse = r_pulse;
   assign decode_instr = r_instr;
   assign decode_pc    = r_pc;
   assign queue_count  = r_count;
   assign issued_total = r_issued;

endmodule
`default_nettype wire
